// File: rtl/ternary_popcount_accum_if.sv
// Beat-in / result-out bundle for ternary_popcount_accum.
// master = input sequencer + downstream layer, slave = the accumulator.
interface ternary_popcount_accum_if #(
  parameter int IN_WIDTH  = 19,
  parameter int MAX_BEATS = 4
);
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int ACC_W = CNT_W + $clog2(MAX_BEATS) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     in_pos;
  logic [IN_WIDTH-1:0]     in_neg;
  logic                    in_last;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [1:0]              out_act;
  logic                    out_ovf;

  modport master (
    output in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
    input  in_ready, out_valid, out_sum, out_act, out_ovf
  );

  modport slave (
    input  in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
    output in_ready, out_valid, out_sum, out_act, out_ovf
  );
endinterface

// File: rtl/ternary_popcount_accum.sv
// Multi-beat ternary neuron: accumulates popcount(pos)-popcount(neg) per beat,
// then applies a two-threshold ternary activation on a registered valid/ready output.
module ternary_popcount_accum #(
  parameter int IN_WIDTH   = 19,
  parameter int MAX_BEATS  = 4,
  parameter int TRUNC_LSBS = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ternary_popcount_accum_if.slave   bus
);
  localparam int CNT_W  = $clog2(IN_WIDTH + 1);
  localparam int ACC_W  = CNT_W + $clog2(MAX_BEATS) + 1;
  localparam int BCNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                  r_state;
  logic                    r_in_ready;
  logic signed [ACC_W-1:0] r_acc;
  logic [BCNT_W-1:0]       r_bcnt;
  logic                    r_ovf;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [1:0]              r_out_act;
  logic                    r_out_ovf;

  logic [CNT_W-1:0]        w_pc_p_raw;
  logic [CNT_W-1:0]        w_pc_n_raw;
  logic [CNT_W-1:0]        w_pc_p;
  logic [CNT_W-1:0]        w_pc_n;
  logic signed [ACC_W-1:0] w_term;
  logic                    w_room;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [BCNT_W-1:0]       w_bcnt_next;
  logic                    w_ovf_next;
  logic [1:0]              w_act;
  logic                    w_in_hs;

  always_comb begin
    w_pc_p_raw = '0;
    w_pc_n_raw = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      w_pc_p_raw = w_pc_p_raw + CNT_W'(bus.in_pos[i]);
      w_pc_n_raw = w_pc_n_raw + CNT_W'(bus.in_neg[i]);
    end
  end

  // Approximation: drop the low TRUNC_LSBS bits of each count independently.
  assign w_pc_p = (w_pc_p_raw >> TRUNC_LSBS) << TRUNC_LSBS;
  assign w_pc_n = (w_pc_n_raw >> TRUNC_LSBS) << TRUNC_LSBS;
  assign w_term = ACC_W'(w_pc_p) - ACC_W'(w_pc_n);

  assign w_in_hs     = bus.in_valid & r_in_ready;
  assign w_room      = (r_bcnt < BCNT_W'(MAX_BEATS));
  assign w_acc_next  = w_room ? (r_acc + w_term) : r_acc;
  assign w_bcnt_next = w_room ? (r_bcnt + BCNT_W'(1)) : r_bcnt;
  assign w_ovf_next  = r_ovf | ~w_room;

  // +1 is tested first so it wins when thr_lo >= thr_hi.
  always_comb begin
    w_act = 2'b00;
    if (w_acc_next >= bus.thr_hi)      w_act = 2'b01;
    else if (w_acc_next <= bus.thr_lo) w_act = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_acc       <= '0;
      r_bcnt      <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_act   <= 2'b00;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_in_hs) begin
            r_acc  <= w_acc_next;
            r_bcnt <= w_bcnt_next;
            r_ovf  <= w_ovf_next;
            if (bus.in_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_next;
              r_out_act   <= w_act;
              r_out_ovf   <= w_ovf_next;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_bcnt      <= '0;
            r_ovf       <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_act   = r_out_act;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_ternary_popcount_accum.sv
// Directed bench for ternary_popcount_accum: vector table of whole transactions
// plus hand sequences for backpressure, truncation and mid-transaction reset.
module tb_ternary_popcount_accum;
  localparam int IN_WIDTH  = 19;
  localparam int MAX_BEATS = 4;
  localparam int ACC_W     = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ternary_popcount_accum_if #(.IN_WIDTH(IN_WIDTH), .MAX_BEATS(MAX_BEATS)) bus ();
  ternary_popcount_accum_if #(.IN_WIDTH(IN_WIDTH), .MAX_BEATS(MAX_BEATS)) bus_t ();

  ternary_popcount_accum #(.IN_WIDTH(IN_WIDTH), .MAX_BEATS(MAX_BEATS), .TRUNC_LSBS(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ternary_popcount_accum #(.IN_WIDTH(IN_WIDTH), .MAX_BEATS(MAX_BEATS), .TRUNC_LSBS(1)) u_dut_t (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_t.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n_beats;
    logic [18:0] pos;
    logic [18:0] neg;
    int          thr_hi;
    int          thr_lo;
    int          exp_sum;
    int          exp_act;
    int          exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_beat(input logic [18:0] p, input logic [18:0] n, input logic last);
    int unsigned waitc;
    waitc        = 0;
    bus.in_valid = 1'b1;
    bus.in_pos   = p;
    bus.in_neg   = n;
    bus.in_last  = last;
    while (!bus.in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic release_result(input string nm);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, int'(bus.out_valid), 0);
    chk({nm, "_ready_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // n_beats, pos, neg, thr_hi, thr_lo, sum, act, ovf
    vecs[0] = '{1, 19'h7FFFF, 19'h00000,  10, -10,  19, 1, 0};
    vecs[1] = '{3, 19'h00007, 19'h0001F,  10,  -6,  -6, 3, 0};
    vecs[2] = '{3, 19'h00007, 19'h0001F,  10,  -7,  -6, 0, 0};
    vecs[3] = '{6, 19'h00001, 19'h00000,  10, -10,   4, 0, 1};
    vecs[4] = '{1, 19'h00000, 19'h7FFFF,  10, -10, -19, 3, 0};
    vecs[5] = '{1, 19'h003FF, 19'h00000,  10, -10,  10, 1, 0};
    vecs[6] = '{2, 19'h00005, 19'h00005,   0,   5,   0, 1, 0};
    vecs[7] = '{4, 19'h7FFFF, 19'h00000,  76, -10,  76, 1, 0};
    vecs[8] = '{5, 19'h00000, 19'h7FFFF,  10, -76, -76, 3, 1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_pos = '0; bus.in_neg = '0; bus.in_last = 1'b0;
    bus.thr_hi = '0; bus.thr_lo = '0; bus.out_ready = 1'b0;
    bus_t.in_valid = 1'b0; bus_t.in_pos = '0; bus_t.in_neg = '0; bus_t.in_last = 1'b0;
    bus_t.thr_hi = ACC_W'(10); bus_t.thr_lo = ACC_W'(-10); bus_t.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_act", int'(bus.out_act), 0);
    chk("rst_out_ovf", int'(bus.out_ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      bus.thr_hi = ACC_W'(vecs[v].thr_hi);
      bus.thr_lo = ACC_W'(vecs[v].thr_lo);
      for (int b = 0; b < vecs[v].n_beats; b++)
        do_beat(vecs[v].pos, vecs[v].neg, (b == vecs[v].n_beats - 1));
      chk($sformatf("v%0d_valid", v), int'(bus.out_valid), 1);
      chk($sformatf("v%0d_sum", v), int'($signed(bus.out_sum)), vecs[v].exp_sum);
      chk($sformatf("v%0d_act", v), int'(bus.out_act), vecs[v].exp_act);
      chk($sformatf("v%0d_ovf", v), int'(bus.out_ovf), vecs[v].exp_ovf);
      release_result($sformatf("v%0d", v));
    end

    // Backpressure: result held, new beat offered but not taken.
    bus.thr_hi = ACC_W'(10);
    bus.thr_lo = ACC_W'(-10);
    do_beat(19'h7FFFF, 19'h0, 1'b1);
    bus.in_valid = 1'b1; bus.in_pos = 19'h00001; bus.in_neg = '0; bus.in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_in_ready", c), int'(bus.in_ready), 0);
      chk($sformatf("bp%0d_valid", c), int'(bus.out_valid), 1);
      chk($sformatf("bp%0d_sum", c), int'($signed(bus.out_sum)), 19);
      chk($sformatf("bp%0d_act", c), int'(bus.out_act), 1);
      @(posedge clk); #1;
    end
    release_result("bp");
    do_beat(19'h00001, 19'h0, 1'b1);
    chk("bp_next_valid", int'(bus.out_valid), 1);
    chk("bp_next_sum", int'($signed(bus.out_sum)), 1);
    release_result("bp_next");

    // Truncated instance: 3->2, 1->0; overlap 2-2.
    bus_t.in_valid = 1'b1; bus_t.in_pos = 19'h7; bus_t.in_neg = 19'h1; bus_t.in_last = 1'b1;
    chk("tr_ready", int'(bus_t.in_ready), 1);
    @(posedge clk); #1;
    bus_t.in_valid = 1'b0;
    chk("tr_valid", int'(bus_t.out_valid), 1);
    chk("tr_sum", int'($signed(bus_t.out_sum)), 2);
    chk("tr_act", int'(bus_t.out_act), 0);
    bus_t.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_t.out_ready = 1'b0;
    chk("tr_ready_back", int'(bus_t.in_ready), 1);
    bus_t.in_valid = 1'b1; bus_t.in_pos = 19'h5; bus_t.in_neg = 19'h5;
    @(posedge clk); #1;
    bus_t.in_valid = 1'b0;
    chk("tr_ovl_valid", int'(bus_t.out_valid), 1);
    chk("tr_ovl_sum", int'($signed(bus_t.out_sum)), 0);

    // Reset after two accumulated beats discards partial state.
    do_beat(19'h7FFFF, 19'h0, 1'b0);
    do_beat(19'h7FFFF, 19'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", int'(bus.in_ready), 0);
    chk("mr_valid", int'(bus.out_valid), 0);
    chk("mr_sum", int'(bus.out_sum), 0);
    chk("mr_act", int'(bus.out_act), 0);
    chk("mr_ovf", int'(bus.out_ovf), 0);
    @(posedge clk); #1;
    chk("mr_in_ready_hold", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    do_beat(19'h00003, 19'h0, 1'b1);
    chk("mr_fresh_valid", int'(bus.out_valid), 1);
    chk("mr_fresh_sum", int'($signed(bus.out_sum)), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
